// File: rtl/buffer_stream_engine.sv
// Streaming copy engine for one BufferInterconnect port: reads src, skids returned data, writes dst.
// Optional forward-overlap start rejection is compiled in with `define BUF_STREAM_OVERLAP_CHECK_EN.
module buffer_stream_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        src_base,
  input  logic [ADDR_W-1:0]        dst_base,
  input  logic [LEN_W-1:0]         len,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [2*ADDR_W+DATA_W:0] ram_req,
  input  logic [DATA_W-1:0]        ram_rdata
);
  localparam int FDEPTH = RD_LAT + 1;
  localparam int PTR_W  = $clog2(FDEPTH);
  localparam int CNT_W  = $clog2(FDEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] src_q, dst_q, raddr, waddr;
  logic [LEN_W-1:0]  len_q, rd_cnt, wr_cnt;
  logic [DATA_W-1:0] wdata;
  logic              wren;
  logic [RD_LAT-1:0] vld_pipe;
  logic [DATA_W-1:0] fifo_mem [FDEPTH];
  logic [PTR_W-1:0]  wp, rp;
  logic [CNT_W-1:0]  fcnt, outst;

  logic              hazard, accept, rd_want, issue, pop, push, credit;
  logic              rd_last, wr_last;
  logic [ADDR_W-1:0] rd_base;
  logic [LEN_W-1:0]  rd_off, cur_len;

  // Bus layout toward the interconnect: {raddr, waddr, wdata, wren}.
  assign ram_req = {raddr, waddr, wdata, wren};
  assign push    = vld_pipe[RD_LAT-1];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef BUF_STREAM_OVERLAP_CHECK_EN
  always_comb begin
    hazard = (dst_base > src_base) &&
             ({1'b0, dst_base} < ({1'b0, src_base} + (ADDR_W+1)'(len)));
  end

  always_ff @(posedge clk) begin
    if (rstn) err <= 1'b0;
    else      err <= (state == S_IDLE) && start && hazard;
  end
`else
  assign hazard = 1'b0;
  assign err    = 1'b0;
`endif

  // outst counts every word issued but not yet written (pipe + FIFO), so the
  // credit test also bounds FIFO occupancy; a same-cycle pop frees a slot.
  always_comb begin
    accept  = (state == S_IDLE) && start && !hazard;
    pop     = (fcnt != '0) && !hold;
    credit  = (outst - CNT_W'(pop)) < CNT_W'(FDEPTH);
    rd_want = (state == S_IDLE) ? (accept && (len != '0)) : (state == S_ISSUE);
    issue   = rd_want && !hold && credit;
    rd_base = (state == S_IDLE) ? src_base : src_q;
    rd_off  = (state == S_IDLE) ? '0 : rd_cnt;
    cur_len = (state == S_IDLE) ? len : len_q;
    rd_last = issue && ((rd_off + LEN_W'(1)) == cur_len);
    wr_last = pop && ((wr_cnt + LEN_W'(1)) == len_q);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      raddr    <= '0;
      waddr    <= '0;
      wdata    <= '0;
      wren     <= 1'b0;
      vld_pipe <= '0;
      wp       <= '0;
      rp       <= '0;
      fcnt     <= '0;
      outst    <= '0;
    end else begin
      done     <= 1'b0;
      wren     <= pop;
      vld_pipe <= {vld_pipe[RD_LAT-2:0], issue};
      fcnt     <= fcnt + CNT_W'(push) - CNT_W'(pop);
      outst    <= outst + CNT_W'(issue) - CNT_W'(pop);

      if (issue) raddr <= rd_base + ADDR_W'(rd_off);
      if (push)  wp <= ptr_inc(wp);
      if (pop) begin
        waddr  <= dst_q + ADDR_W'(wr_cnt);
        wdata  <= fifo_mem[rp];
        rp     <= ptr_inc(rp);
        wr_cnt <= wr_cnt + LEN_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            src_q  <= src_base;
            dst_q  <= dst_base;
            len_q  <= len;
            busy   <= 1'b1;
            wr_cnt <= '0;
            rd_cnt <= issue ? LEN_W'(1) : '0;
            if (len == '0)   state <= S_FIN;
            else if (rd_last) state <= S_DRAIN;
            else              state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            rd_cnt <= rd_cnt + LEN_W'(1);
            if (rd_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wr_last) state <= S_FIN;
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_stream_engine.sv
// Scoreboard bench for buffer_stream_engine: stimulus queues expected reads/writes, a monitor checks them.
module tb_buffer_stream_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int RL = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;
  logic [2*AW+DW:0] ram_req;
  logic [DW-1:0] ram_rdata = '0;

  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wdata;
  logic          wren;
  assign raddr = ram_req[2*AW+DW:AW+DW+1];
  assign waddr = ram_req[AW+DW:DW+1];
  assign wdata = ram_req[DW:1];
  assign wren  = ram_req[0];

  buffer_stream_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(RL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src_base(src_base), .dst_base(dst_base),
    .len(len), .hold(hold), .busy(busy), .done(done), .err(err),
    .ram_req(ram_req), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int e_start = 0;
  logic [AW-1:0]    rq [$];
  logic [AW+DW-1:0] wq [$];
  bit rd_chk = 1'b1;
  bit first_pend = 1'b0, done_pend = 1'b0, err_pend = 1'b0;
  int first_exp = 0, done_exp = 0;
  logic [AW-1:0] prev_raddr = '0;
  logic [AW-1:0] hist [RL];

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic int rel();
    return ecnt - e_start + 1;
  endfunction

  always @(posedge clk) ecnt++;

  // Model interconnect: data for an address sampled after a read edge is
  // sampled by the DUT RL edges later.
  always @(negedge clk) begin
    for (int i = RL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = raddr;
    ram_rdata = mem_f(hist[RL-1]);
  end

  always @(negedge clk) begin
    logic [AW+DW-1:0] ew;
    logic [AW-1:0] er;
    if (!rstn) begin
      if (wren) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL stray_write: got waddr=%h wdata=%h, want no write", waddr, wdata);
        end else begin
          ew = wq.pop_front();
          if ({waddr, wdata} !== ew) begin
            failures++;
            $display("FAIL write: got waddr=%h wdata=%h, want waddr=%h wdata=%h",
                     waddr, wdata, ew[AW+DW-1:DW], ew[DW-1:0]);
          end
        end
        if (first_pend) begin
          first_pend = 1'b0;
          checks++;
          if (rel() != first_exp) begin
            failures++;
            $display("FAIL first_wren_cycle: got %0d want %0d", rel(), first_exp);
          end
        end
      end
      if (rd_chk && (raddr !== prev_raddr)) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL stray_read: got raddr=%h, want no read", raddr);
        end else begin
          er = rq.pop_front();
          if (raddr !== er) begin
            failures++;
            $display("FAIL read: got raddr=%h want %h", raddr, er);
          end
        end
      end
      if (done) begin
        checks++;
        if (!done_pend) begin
          failures++;
          $display("FAIL stray_done: got done=1 at cycle %0d, want 0", rel());
        end else if (done_exp != 0 && rel() != done_exp) begin
          failures++;
          $display("FAIL done_cycle: got %0d want %0d", rel(), done_exp);
        end
        done_pend = 1'b0;
      end
      if (err) begin
        checks++;
        if (!err_pend) begin
          failures++;
          $display("FAIL stray_err: got err=1 at cycle %0d, want 0", rel());
        end
        err_pend = 1'b0;
      end
    end
    prev_raddr = raddr;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                    input int exp_d, input int exp_first, input bit expect_rsp);
    if (expect_rsp) begin
      for (int i = 0; i < int'(n); i++) begin
        logic [AW-1:0] ra;
        ra = s + AW'(i);
        rq.push_back(ra);
        wq.push_back({d + AW'(i), mem_f(ra)});
      end
      first_pend = (n != '0);
      first_exp  = exp_first;
      done_pend  = 1'b1;
      done_exp   = exp_d;
    end
    src_base = s; dst_base = d; len = n; start = 1'b1;
    e_start  = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (rel() < n) @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: got no done within %0d cycles, want done", max_cyc);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", ram_req, 0);
    rstn = 1'b0;
    @(negedge clk);

    // 1: basic len=8 copy
    go(32'h10, 32'h100, 16'd8, 15, 7, 1'b1);
    chk("t1_busy_c1", busy, 1);
    wait_done(40);
    chk("t1_busy_done", busy, 0);
    repeat (2) @(negedge clk);

    // 2: zero-length transfer
    go(32'h50, 32'h500, 16'd0, 2, 0, 1'b1);
    chk("t2_busy_c1", busy, 1);
    @(negedge clk);
    chk("t2_done_c2", done, 1);
    chk("t2_busy_c2", busy, 0);
    repeat (3) @(negedge clk);

    // 3: hold over cycles 4..12 with len=16
    go(32'h1000, 32'h2000, 16'd16, 32, 14, 1'b1);
    wait_rel(4);
    hold = 1'b1;
    wait_rel(13);
    hold = 1'b0;
    wait_done(60);
    repeat (2) @(negedge clk);

    // 4: address wrap
    go(32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'd4, 11, 7, 1'b1);
    wait_done(40);
    repeat (2) @(negedge clk);

    // 5: reset mid-transfer, restart, ignored start while busy
    rd_chk = 1'b0;
    go(32'h300, 32'h600, 16'd8, 0, 0, 1'b0);
    wait_rel(6);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("t5_wren_after_rst", wren, 0);
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_done_after_rst", done, 0);
    repeat (2) @(negedge clk);
    rd_chk = 1'b1;
    go(32'h40, 32'h200, 16'd8, 15, 7, 1'b1);
    wait_rel(3);
    src_base = 32'h80; dst_base = 32'h300; len = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_ignored_start", busy, 1);
    wait_done(40);
    repeat (2) @(negedge clk);

    // 6: forward-overlap start
`ifdef BUF_STREAM_OVERLAP_CHECK_EN
    err_pend = 1'b1;
    go(32'h20, 32'h24, 16'd8, 0, 0, 1'b0);
    chk("t6_err_c1", err, 1);
    chk("t6_busy_c1", busy, 0);
    @(negedge clk);
    chk("t6_err_c2", err, 0);
    chk("t6_busy_c2", busy, 0);
    repeat (12) @(negedge clk);
`else
    go(32'h20, 32'h24, 16'd8, 15, 7, 1'b1);
    chk("t6_err_c1", err, 0);
    wait_done(40);
    repeat (2) @(negedge clk);
`endif
    go(32'h20, 32'h28, 16'd8, 15, 7, 1'b1);
    wait_done(40);
    repeat (3) @(negedge clk);

    chk("rd_queue_empty", rq.size(), 0);
    chk("wr_queue_empty", wq.size(), 0);
    chk("done_consumed", done_pend, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
